// File: rtl/result_quant_stream_pkg.sv
// Shared constants for the result requantization stream: FSM encoding,
// default widths and the saturation limits derived from the output width.
package result_quant_stream_pkg;

  localparam int unsigned DefOutWidth  = 8;
  localparam int unsigned DefFifoDepth = 16;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // Largest / smallest value representable in a signed word of width w.
  function automatic int sat_hi(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int unsigned w);
    return -(1 << (w - 1));
  endfunction

  localparam int DefSatHi = sat_hi(DefOutWidth);
  localparam int DefSatLo = sat_lo(DefOutWidth);

endpackage

// File: rtl/result_quant_stream_if.sv
// Valid/ready output stream carrying one quantized word and its address.
interface result_quant_stream_if
  import result_quant_stream_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 16,
  parameter int unsigned OUT_WIDTH = DefOutWidth
);
  logic                        o_valid;
  logic                        i_ready;
  logic [ADDR_SIZE-1:0]        o_addr;
  logic signed [OUT_WIDTH-1:0] o_data;

  modport master (output o_valid, output o_addr, output o_data, input i_ready);
  modport slave  (input o_valid, input o_addr, input o_data, output i_ready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. A push while full is accepted
// only when a pop frees a slot on the same edge; pop while empty is ignored.
module sync_fifo_fwft #(
  parameter int unsigned Width = 24,
  parameter int unsigned Depth = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [Width-1:0]           wdata_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);
  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy state; reset flushes the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/result_quant_stream.sv
// Requantizes GEMM result-RAM writes (round-half-up shift, optional ReLU,
// signed saturation), buffers them with their address and streams them out.
module result_quant_stream
  import result_quant_stream_pkg::*;
#(
  parameter int unsigned RESULT_SIZE = 32,
  parameter int unsigned ADDR_SIZE   = 16,
  parameter int unsigned OUT_WIDTH   = DefOutWidth,
  parameter int unsigned SHIFT_W     = 5,
  parameter int unsigned FIFO_DEPTH  = DefFifoDepth
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [SHIFT_W-1:0]            cfg_shift,
  input  logic                          cfg_relu,
  input  logic [ADDR_SIZE-1:0]          i_result_addr,
  input  logic signed [RESULT_SIZE-1:0] i_result_save,
  input  logic                          i_ena,
  input  logic                          i_wea,
  input  logic                          i_w_done,
  result_quant_stream_if.master         out_if,
  output logic                          o_almost_full,
  output logic                          o_overflow,
  output logic [ADDR_SIZE:0]            o_count,
  output logic                          o_busy,
  output logic                          o_done
);
  localparam int unsigned AccW = RESULT_SIZE + 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic signed [AccW-1:0] SatHi = AccW'(sat_hi(OUT_WIDTH));
  localparam logic signed [AccW-1:0] SatLo = AccW'(sat_lo(OUT_WIDTH));

  logic [1:0]                  state_q, state_d;
  logic [SHIFT_W-1:0]          shift_q, shift_d;
  logic                        relu_q, relu_d;
  logic                        s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [ADDR_SIZE-1:0]        s1_addr_q, s2_addr_q;
  logic signed [AccW-1:0]      s1_val_q, s1_val_d, acc_ext, rnd, relu_val;
  logic signed [OUT_WIDTH-1:0] s2_data_q, s2_data_d;
  logic                        overflow_q, overflow_d;
  logic [ADDR_SIZE:0]          count_q, count_d;
  logic                        fifo_full, fifo_empty, pop, arm;
  logic [CntW-1:0]             fifo_count;
  logic [ADDR_SIZE+OUT_WIDTH-1:0] fifo_rdata;

  assign arm = (state_q == StIdle) && start;
  assign pop = out_if.o_valid && out_if.i_ready;

  // Stage 1: round-half-up arithmetic shift, one extra bit so the bias never wraps.
  always_comb begin
    acc_ext  = {i_result_save[RESULT_SIZE-1], i_result_save};
    rnd      = '0;
    s1_val_d = acc_ext;
    if (shift_q != '0) begin
      rnd      = AccW'(1) << (shift_q - SHIFT_W'(1));
      s1_val_d = (acc_ext + rnd) >>> shift_q;
    end
  end

  // Stage 2: optional ReLU then clamp to the signed output range.
  always_comb begin
    relu_val = s1_val_q;
    if (relu_q && (s1_val_q < 0)) relu_val = '0;
    if (relu_val > SatHi)      s2_data_d = SatHi[OUT_WIDTH-1:0];
    else if (relu_val < SatLo) s2_data_d = SatLo[OUT_WIDTH-1:0];
    else                       s2_data_d = relu_val[OUT_WIDTH-1:0];
  end

  // FSM, config latch, pipeline valids, overflow flag and transfer counter.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    relu_d     = relu_q;
    overflow_d = overflow_q;
    count_d    = pop ? count_q + (ADDR_SIZE + 1)'(1) : count_q;
    s1_valid_d = (state_q == StRun) && i_ena && i_wea;
    s2_valid_d = s1_valid_q;
    // Stage-2 word meeting a full FIFO with no pop is lost.
    if (s2_valid_q && fifo_full && !pop) overflow_d = 1'b1;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRun;
          shift_d    = cfg_shift;
          relu_d     = cfg_relu;
          overflow_d = 1'b0;
          count_d    = '0;
          s2_valid_d = 1'b0;
        end
      end
      StRun:   if (i_w_done) state_d = StDrain;
      StDrain: if (!s1_valid_q && !s2_valid_q && fifo_empty) state_d = StDone;
      default: state_d = StIdle;
    endcase
    if (arm) s1_valid_d = 1'b0;
  end

  // All block state; asynchronous reset returns to an idle, empty block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s2_addr_q  <= '0;
      s1_val_q   <= '0;
      s2_data_q  <= '0;
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      relu_q     <= relu_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_addr_q  <= i_result_addr;
      s2_addr_q  <= s1_addr_q;
      s1_val_q   <= s1_val_d;
      s2_data_q  <= s2_data_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
    end
  end

  sync_fifo_fwft #(
    .Width (ADDR_SIZE + OUT_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s2_valid_q),
    .pop_i   (pop),
    .wdata_i ({s2_addr_q, s2_data_q}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign out_if.o_valid = !fifo_empty;
  assign out_if.o_addr  = fifo_rdata[ADDR_SIZE+OUT_WIDTH-1:OUT_WIDTH];
  assign out_if.o_data  = fifo_rdata[OUT_WIDTH-1:0];
  assign o_almost_full  = (fifo_count >= CntW'(FIFO_DEPTH - 2));
  assign o_overflow     = overflow_q;
  assign o_count        = count_q;
  assign o_busy         = (state_q != StIdle);
  assign o_done         = (state_q == StDone);

endmodule

// File: tb/tb_result_quant_stream.sv
// Scoreboard bench: stimulus pushes hand-computed {addr,data} words, a
// monitor pops and compares on every stream transfer.
module tb_result_quant_stream;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  cfg_shift;
  logic        cfg_relu;
  logic [15:0] i_result_addr;
  logic signed [31:0] i_result_save;
  logic        i_ena, i_wea, i_w_done;
  logic        o_almost_full, o_overflow, o_busy, o_done;
  logic [16:0] o_count;

  int vec = 0;
  int err = 0;
  int done_cnt = 0;
  logic done_prev = 1'b0;
  logic [23:0] exp_q[$];

  result_quant_stream_if #(.ADDR_SIZE(16), .OUT_WIDTH(8)) sif ();

  result_quant_stream dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_shift     (cfg_shift),
    .cfg_relu      (cfg_relu),
    .i_result_addr (i_result_addr),
    .i_result_save (i_result_save),
    .i_ena         (i_ena),
    .i_wea         (i_wea),
    .i_w_done      (i_w_done),
    .out_if        (sif),
    .o_almost_full (o_almost_full),
    .o_overflow    (o_overflow),
    .o_count       (o_count),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: compare each transferred word, track o_done pulses.
  always @(negedge clk) begin
    logic [23:0] e;
    if (!rst) begin
      if (sif.o_valid && sif.i_ready) begin
        if (exp_q.size() == 0) begin
          vec++;
          err++;
          $display("FAIL unexpected_word: got addr=%h data=%h want none",
                   sif.o_addr, sif.o_data);
        end else begin
          e = exp_q.pop_front();
          check("stream_word", {8'h0, sif.o_addr, sif.o_data}, {8'h0, e});
        end
      end
      if (done_prev) begin
        check("busy_falls_after_done", {31'h0, o_busy}, 32'h0);
        check("done_single_pulse", {31'h0, o_done}, 32'h0);
      end
      if (o_done) begin
        done_cnt++;
        check("done_when_empty", {31'h0, sif.o_valid}, 32'h0);
      end
      done_prev = o_done;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [4:0] sh, input logic relu);
    cfg_shift = sh;
    cfg_relu  = relu;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input int acc, input logic done,
                    input logic keep, input int d);
    i_result_addr = a;
    i_result_save = acc;
    i_ena         = 1'b1;
    i_wea         = 1'b1;
    i_w_done      = done;
    if (keep) exp_q.push_back({a, d[7:0]});
    @(posedge clk);
    #1;
    i_ena    = 1'b0;
    i_wea    = 1'b0;
    i_w_done = 1'b0;
  endtask

  task automatic done_pulse();
    i_w_done = 1'b1;
    @(posedge clk);
    #1;
    i_w_done = 1'b0;
  endtask

  task automatic wait_done();
    int c0;
    int n;
    c0 = done_cnt;
    n  = 0;
    while (done_cnt == c0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_pulse", done_cnt - c0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; cfg_shift = '0; cfg_relu = 1'b0;
    i_result_addr = '0; i_result_save = '0; i_ena = 1'b0; i_wea = 1'b0; i_w_done = 1'b0;
    sif.i_ready = 1'b0;
    idle(3);
    check("rst_valid", {31'h0, sif.o_valid}, 32'h0);
    check("rst_busy", {31'h0, o_busy}, 32'h0);
    check("rst_done", {31'h0, o_done}, 32'h0);
    check("rst_count", {15'h0, o_count}, 32'h0);
    check("rst_overflow", {31'h0, o_overflow}, 32'h0);
    check("rst_almost_full", {31'h0, o_almost_full}, 32'h0);
    rst = 1'b0;
    idle(1);

    // Writes in IDLE are ignored.
    wr(16'h0BAD, 50, 1'b0, 1'b0, 0);
    idle(4);
    check("idle_write_ignored", {31'h0, sif.o_valid}, 32'h0);

    // Rounding and saturation, shift 4, with latency check on the first word.
    sif.i_ready = 1'b1;
    do_start(5'd4, 1'b0);
    wr(16'h0010, 40, 1'b0, 1'b1, 3);
    @(negedge clk); check("lat_after_e0", {31'h0, sif.o_valid}, 32'h0);
    @(negedge clk); check("lat_after_e1", {31'h0, sif.o_valid}, 32'h0);
    @(negedge clk); check("lat_after_e2", {31'h0, sif.o_valid}, 32'h1);
    @(posedge clk); #1;
    wr(16'h0011, -40, 1'b0, 1'b1, -2);
    wr(16'h0012, 5000, 1'b0, 1'b1, 127);
    wr(16'h0013, -5000, 1'b1, 1'b1, -128);
    wait_done();
    check("count_t1", {15'h0, o_count}, 32'd4);

    // ReLU with shift 0.
    do_start(5'd0, 1'b1);
    wr(16'h0020, -1, 1'b0, 1'b1, 0);
    wr(16'h0021, 0, 1'b0, 1'b1, 0);
    wr(16'h0022, 100, 1'b0, 1'b1, 100);
    wr(16'h0023, 200, 1'b1, 1'b1, 127);
    wait_done();

    // Backpressure, almost-full threshold and overflow.
    sif.i_ready = 1'b0;
    do_start(5'd0, 1'b0);
    for (int i = 0; i < 13; i++) wr(16'h0100 + 16'(i), i, 1'b0, 1'b1, i);
    idle(4);
    check("af_at_13", {31'h0, o_almost_full}, 32'h0);
    wr(16'h010D, 13, 1'b0, 1'b1, 13);
    idle(4);
    check("af_at_14", {31'h0, o_almost_full}, 32'h1);
    wr(16'h010E, 14, 1'b0, 1'b1, 14);
    wr(16'h010F, 15, 1'b0, 1'b1, 15);
    idle(4);
    check("no_ovf_at_16", {31'h0, o_overflow}, 32'h0);
    for (int i = 16; i < 20; i++) wr(16'h0100 + 16'(i), i, 1'b0, 1'b0, i);
    idle(4);
    check("ovf_set", {31'h0, o_overflow}, 32'h1);
    check("count_before_release", {15'h0, o_count}, 32'h0);
    sif.i_ready = 1'b1;
    idle(20);
    check("count_t3", {15'h0, o_count}, 32'd16);
    check("queue_empty_t3", exp_q.size(), 32'd0);
    done_pulse();
    wait_done();
    check("ovf_sticky", {31'h0, o_overflow}, 32'h1);

    // Full FIFO with a pop on the same edge as the push.
    sif.i_ready = 1'b0;
    do_start(5'd0, 1'b0);
    check("ovf_cleared_on_start", {31'h0, o_overflow}, 32'h0);
    for (int i = 0; i < 16; i++) wr(16'h0200 + 16'(i), i + 20, 1'b0, 1'b1, i + 20);
    idle(4);
    wr(16'h0210, 99, 1'b0, 1'b1, 99);
    @(posedge clk); #1 sif.i_ready = 1'b1;
    @(posedge clk); #1 sif.i_ready = 1'b0;
    idle(2);
    check("full_pop_no_ovf", {31'h0, o_overflow}, 32'h0);
    check("full_pop_still_af", {31'h0, o_almost_full}, 32'h1);
    sif.i_ready = 1'b1;
    idle(25);
    check("count_t4", {15'h0, o_count}, 32'd17);
    done_pulse();
    wait_done();

    // Drain with toggling ready; last write with w_done; DRAIN writes dropped.
    sif.i_ready = 1'b0;
    do_start(5'd3, 1'b0);
    fork
      begin
        repeat (40) begin
          @(posedge clk);
          #1 sif.i_ready = ~sif.i_ready;
        end
      end
      begin
        wr(16'h0300, 16, 1'b0, 1'b1, 2);
        wr(16'h0301, -12, 1'b0, 1'b1, -1);
        wr(16'h0302, 1000, 1'b1, 1'b1, 125);
        wr(16'h0303, 500, 1'b0, 1'b0, 0);
        wr(16'h0304, -500, 1'b0, 1'b0, 0);
        wait_done();
        check("count_t5", {15'h0, o_count}, 32'd3);
        check("busy_after_t5", {31'h0, o_busy}, 32'h0);
      end
    join
    sif.i_ready = 1'b0;

    // Reset in the middle of a run with words buffered.
    do_start(5'd2, 1'b0);
    for (int i = 0; i < 5; i++) wr(16'h0350 + 16'(i), i, 1'b0, 1'b0, 0);
    idle(4);
    check("pre_reset_valid", {31'h0, sif.o_valid}, 32'h1);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("reset_valid_low", {31'h0, sif.o_valid}, 32'h0);
    check("reset_busy_low", {31'h0, o_busy}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    idle(3);
    check("no_done_on_reset", done_cnt - d0, 32'd0);
    sif.i_ready = 1'b1;
    do_start(5'd2, 1'b0);
    wr(16'h0400, 7, 1'b0, 1'b1, 2);
    wr(16'h0401, -6, 1'b1, 1'b1, -1);
    wait_done();
    check("count_t6", {15'h0, o_count}, 32'd2);
    check("ovf_t6", {31'h0, o_overflow}, 32'h0);
    check("queue_empty_end", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
